// File: rtl/drr_egress_scheduler.sv
// Packet-granular egress arbiter: shares one AXI-Stream TX port among N_QUEUE
// queues using strict priority or byte-weighted deficit round robin.
module drr_egress_scheduler #(
  parameter int N_QUEUE         = 3,
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH/8,
  parameter int QUANTUM_WIDTH   = 16,
  parameter int DEFICIT_WIDTH   = QUANTUM_WIDTH+2,
  parameter int QSEL_WIDTH      = $clog2(N_QUEUE)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [N_QUEUE*AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [N_QUEUE*AXIS_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic [N_QUEUE-1:0]                   s_axis_tvalid,
  output logic [N_QUEUE-1:0]                   s_axis_tready,
  input  logic [N_QUEUE-1:0]                   s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic                                 m_axis_tlast,
  input  logic                                 cfg_enable,
  input  logic                                 cfg_mode,
  input  logic [N_QUEUE*QUANTUM_WIDTH-1:0]     cfg_quantum,
  input  logic                                 cfg_stat_clear,
  output logic [QSEL_WIDTH-1:0]                grant_queue,
  output logic                                 busy,
  output logic [N_QUEUE*32-1:0]                stat_pkt_count
);

  typedef enum logic {SELECT, XFER} state_t;

  localparam int unsigned NQ        = N_QUEUE;
  localparam int          CNT_WIDTH = $clog2(AXIS_KEEP_WIDTH+1);
  localparam logic signed [DEFICIT_WIDTH:0] DMAX = {2'b00, {(DEFICIT_WIDTH-1){1'b1}}};

  state_t                          state, state_next;
  logic [QSEL_WIDTH-1:0]           rr_ptr, cand;
  logic                            found, grant_ok, hs, xfer_mode;
  int unsigned                     idx;
  logic signed [DEFICIT_WIDTH-1:0] deficit [N_QUEUE];
  logic [31:0]                     stat [N_QUEUE];
  logic [AXIS_DATA_WIDTH-1:0]      sel_data;
  logic [AXIS_KEEP_WIDTH-1:0]      sel_keep;
  logic                            sel_valid, sel_last;
  logic [CNT_WIDTH-1:0]            beat_bytes;
  logic [QUANTUM_WIDTH-1:0]        cand_quantum;
  logic signed [DEFICIT_WIDTH-1:0] cand_deficit, refill_deficit, spent_deficit;

  function automatic logic signed [DEFICIT_WIDTH-1:0] sat(input logic signed [DEFICIT_WIDTH:0] v);
    logic signed [DEFICIT_WIDTH:0] r;
    r = v;
    if (v > DMAX) r = DMAX;
    else if (v < -DMAX) r = -DMAX;
    return r[DEFICIT_WIDTH-1:0];
  endfunction

  function automatic logic [QSEL_WIDTH-1:0] next_q(input logic [QSEL_WIDTH-1:0] q);
    return (32'(q) == NQ - 1) ? '0 : q + 1'b1;
  endfunction

  // Strict mode scans from queue 0; DRR scans upward from rr_ptr with wrap.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NQ; k++) begin
      idx = cfg_mode ? 32'(rr_ptr) + k : k;
      if (idx >= NQ) idx = idx - NQ;
      if (!found && s_axis_tvalid[QSEL_WIDTH'(idx)]) begin
        found = 1'b1;
        cand  = QSEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    sel_data  = s_axis_tdata[int'(grant_queue)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
    sel_keep  = s_axis_tkeep[int'(grant_queue)*AXIS_KEEP_WIDTH +: AXIS_KEEP_WIDTH];
    sel_valid = s_axis_tvalid[grant_queue];
    sel_last  = s_axis_tlast[grant_queue];
    beat_bytes = '0;
    for (int unsigned b = 0; b < AXIS_KEEP_WIDTH; b++)
      beat_bytes = beat_bytes + CNT_WIDTH'(sel_keep[b]);
  end

  always_comb begin
    cand_quantum   = cfg_quantum[int'(cand)*QUANTUM_WIDTH +: QUANTUM_WIDTH];
    cand_deficit   = deficit[cand];
    refill_deficit = sat({cand_deficit[DEFICIT_WIDTH-1], cand_deficit}
                     + {{(DEFICIT_WIDTH+1-QUANTUM_WIDTH){1'b0}},
                        (cand_quantum == '0) ? QUANTUM_WIDTH'(1) : cand_quantum});
    spent_deficit  = sat({deficit[grant_queue][DEFICIT_WIDTH-1], deficit[grant_queue]}
                     - {{(DEFICIT_WIDTH+1-CNT_WIDTH){1'b0}}, beat_bytes});
    grant_ok       = cfg_enable && found && (!cfg_mode || cand_deficit > 0);
    hs             = (state == XFER) && sel_valid && m_axis_tready;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SELECT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SELECT:  if (grant_ok) state_next = XFER;
      XFER:    if (hs && sel_last) state_next = SELECT;
      default: state_next = SELECT;
    endcase
  end

  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    busy          = 1'b0;
    if (state == XFER) begin
      m_axis_tdata               = sel_data;
      m_axis_tkeep               = sel_keep;
      m_axis_tvalid              = sel_valid;
      m_axis_tlast               = sel_last;
      s_axis_tready[grant_queue] = m_axis_tready;
      busy                       = 1'b1;
    end
  end

  // Deficit bookkeeping during XFER follows the mode captured at grant time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      grant_queue <= '0;
      xfer_mode   <= 1'b0;
      for (int unsigned i = 0; i < NQ; i++) begin
        deficit[QSEL_WIDTH'(i)] <= '0;
        stat[QSEL_WIDTH'(i)]    <= '0;
      end
    end else begin
      if (state == SELECT) begin
        if (cfg_mode)
          for (int unsigned i = 0; i < NQ; i++)
            if (!s_axis_tvalid[QSEL_WIDTH'(i)]) deficit[QSEL_WIDTH'(i)] <= '0;
        if (grant_ok) begin
          grant_queue <= cand;
          xfer_mode   <= cfg_mode;
        end else if (cfg_enable && found) begin
          deficit[cand] <= refill_deficit;
          rr_ptr        <= next_q(cand);
        end
      end else if (hs) begin
        if (xfer_mode) deficit[grant_queue] <= spent_deficit;
        if (sel_last) begin
          stat[grant_queue] <= stat[grant_queue] + 32'd1;
          if (xfer_mode) rr_ptr <= (spent_deficit > 0) ? grant_queue : next_q(grant_queue);
        end
      end
      if (cfg_stat_clear)
        for (int unsigned i = 0; i < NQ; i++) stat[QSEL_WIDTH'(i)] <= '0;
    end
  end

  always_comb begin
    stat_pkt_count = '0;
    for (int unsigned i = 0; i < NQ; i++)
      stat_pkt_count[i*32 +: 32] = stat[QSEL_WIDTH'(i)];
  end

endmodule
